// File: rtl/mem_rmw_pkg.sv
// Shared types and lane helpers for the data-memory initiator (mem_rmw_master).
// Build option MEM_RMW_ERR_EN (see mem_rmw_master) does not affect this package.
package mem_rmw_pkg;

    localparam int unsigned DEFAULT_MEM_WORDS = 64;

    typedef enum logic [1:0] {
        SZ_B = 2'b00,
        SZ_H = 2'b01,
        SZ_W = 2'b10
    } size_e;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StRmwRd,
        StStore,
        StResp
    } state_e;

    // Pull the addressed lane down to bit 0 and sign/zero extend it.
    function automatic logic [31:0] lane_extract(input logic [31:0] word, input size_e size,
                                                 input logic [1:0] lane, input logic is_unsigned);
        logic [31:0] sh;
        sh = word >> {lane, 3'b000};
        case (size)
            SZ_B:    lane_extract = {{24{~is_unsigned & sh[7]}}, sh[7:0]};
            SZ_H:    lane_extract = {{16{~is_unsigned & sh[15]}}, sh[15:0]};
            default: lane_extract = word;
        endcase
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old, input logic [31:0] data,
                                               input size_e size, input logic [1:0] lane);
        logic [31:0] mask;
        case (size)
            SZ_B:    mask = 32'h0000_00ff << {lane, 3'b000};
            SZ_H:    mask = 32'h0000_ffff << {lane, 3'b000};
            default: mask = 32'hffff_ffff;
        endcase
        lane_merge = (old & ~mask) | ((data << {lane, 3'b000}) & mask);
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational byte-lane extract/extend for loads and merge for read-modify-write stores.
// Build option MEM_RMW_ERR_EN (see mem_rmw_master) does not affect this module.
module mem_lane_merge
    import mem_rmw_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    input  size_e       size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    output logic [31:0] ext_data,
    output logic [31:0] merged
);

    always_comb begin
        ext_data = lane_extract(rdata, size, lane, is_unsigned);
        merged   = lane_merge(rdata, wdata, size, lane);
    end

endmodule

// File: rtl/mem_rmw_master.sv
// Load/store initiator for a 32-bit async-read, sync-write memory; sub-word stores use RMW.
// Define MEM_RMW_ERR_EN to report misaligned/out-of-range requests instead of wrapping.
module mem_rmw_master
    import mem_rmw_pkg::*;
#(
    parameter int unsigned MEM_WORDS = DEFAULT_MEM_WORDS
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    input  logic [31:0] req_addr_i32,
    input  logic [31:0] req_wdata_i32,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o32,
    output logic        rsp_err_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o32,
    output logic [31:0] mem_wdata_o32,
    input  logic [31:0] mem_rdata_i32
);

    localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);

    state_e      state;
    size_e       size_q;
    logic [1:0]  lane_q;
    logic        uns_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic        mem_we_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_valid_q;
    logic        rsp_err_q;

    size_e       req_size;
    logic [1:0]  req_lane;
    logic [31:0] word_addr;
    logic        req_err;
    logic [31:0] ext_data;
    logic [31:0] merged;

    always_comb begin
        req_size = (req_size_i == 2'b11) ? SZ_W : size_e'(req_size_i);
        case (req_size)
            SZ_B:    req_lane = req_addr_i32[1:0];
            SZ_H:    req_lane = {req_addr_i32[1], 1'b0};
            default: req_lane = 2'b00;
        endcase
        word_addr = (req_addr_i32 % MEM_BYTES) & 32'hffff_fffc;
`ifdef MEM_RMW_ERR_EN
        req_err = (req_size_i == 2'b11)
                || ((req_size_i == 2'b01) && req_addr_i32[0])
                || ((req_size_i == 2'b10) && (req_addr_i32[1:0] != 2'b00))
                || (req_addr_i32 >= MEM_BYTES);
`else
        req_err = 1'b0;
`endif
    end

    // mem_wdata_q carries the raw store data until RMW_RD replaces it with the merged word.
    mem_lane_merge u_lane_merge (
        .rdata       (mem_rdata_i32),
        .wdata       (mem_wdata_q),
        .size        (size_q),
        .lane        (lane_q),
        .is_unsigned (uns_q),
        .ext_data    (ext_data),
        .merged      (merged)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= StIdle;
            size_q      <= SZ_W;
            lane_q      <= 2'b00;
            uns_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (req_valid_i) begin
                        size_q      <= req_size;
                        lane_q      <= req_lane;
                        uns_q       <= req_unsigned_i;
                        mem_wdata_q <= req_wdata_i32;
                        rsp_rdata_q <= '0;
                        if (req_err) begin
                            rsp_err_q   <= 1'b1;
                            rsp_valid_q <= 1'b1;
                            state       <= StResp;
                        end else begin
                            mem_addr_q <= word_addr;
                            if (!req_we_i) begin
                                state <= StLoad;
                            end else if (req_size == SZ_W) begin
                                mem_we_q <= 1'b1;
                                state    <= StStore;
                            end else begin
                                state <= StRmwRd;
                            end
                        end
                    end
                end
                StLoad: begin
                    rsp_rdata_q <= ext_data;
                    rsp_valid_q <= 1'b1;
                    mem_addr_q  <= '0;
                    state       <= StResp;
                end
                StRmwRd: begin
                    mem_wdata_q <= merged;
                    mem_we_q    <= 1'b1;
                    state       <= StStore;
                end
                StStore: begin
                    mem_we_q    <= 1'b0;
                    mem_addr_q  <= '0;
                    rsp_valid_q <= 1'b1;
                    state       <= StResp;
                end
                StResp: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        rsp_rdata_q <= '0;
                        rsp_err_q   <= 1'b0;
                        state       <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign req_ready_o   = (state == StIdle);
    assign rsp_valid_o   = rsp_valid_q;
    assign rsp_rdata_o32 = rsp_rdata_q;
    assign rsp_err_o     = rsp_err_q;
    // A store cycle that coincides with reset must not reach the memory.
    assign mem_we_o      = mem_we_q & ~rst_i;
    assign mem_addr_o32  = mem_addr_q;
    assign mem_wdata_o32 = mem_wdata_q;

endmodule
